// File: rtl/simon_sequence_player.sv
// rtl/simon_sequence_player.sv - tick-paced Simon colour sequence playback onto one-hot LEDs
module simon_sequence_player #(
  parameter int SEQ_MAX   = 32,
  parameter int ON_TICKS  = 2,
  parameter int OFF_TICKS = 1,
  localparam int AW = $clog2(SEQ_MAX)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          start,
  input  logic          abort,
  input  logic [AW:0]   length,
  output logic [AW-1:0] rd_addr,
  input  logic [1:0]    rd_data,
  output logic [3:0]    led,
  output logic          busy,
  output logic          done
);

  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [AW:0]   MAX_LEN  = (AW+1)'(SEQ_MAX);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ON,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [TW-1:0]   tick_cnt;
  logic [AW:0]     len_q;
  logic            last_entry;

  function automatic logic [3:0] onehot(input logic [1:0] colour);
    onehot = 4'b0001 << colour;
  endfunction

  assign last_entry = ({1'b0, idx} == (len_q - 1'b1));
  assign rd_addr    = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      tick_cnt <= '0;
      len_q    <= '0;
      led      <= 4'b0000;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      // abort outranks both start and tick, and suppresses the done pulse
      if (abort) begin
        state    <= S_IDLE;
        idx      <= '0;
        tick_cnt <= '0;
        led      <= 4'b0000;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (length != '0) begin
                len_q <= (length > MAX_LEN) ? MAX_LEN : length;
                idx   <= '0;
                busy  <= 1'b1;
                state <= S_LOAD;
              end else begin
                state <= S_DONE;
              end
            end
          end
          S_LOAD: begin
            led      <= onehot(rd_data);
            tick_cnt <= '0;
            state    <= S_ON;
          end
          S_ON: begin
            if (tick) begin
              if (tick_cnt == ON_LAST) begin
                led      <= 4'b0000;
                tick_cnt <= '0;
                state    <= S_GAP;
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          S_GAP: begin
            if (tick) begin
              if (tick_cnt == OFF_LAST) begin
                tick_cnt <= '0;
                if (last_entry) begin
                  busy  <= 1'b0;
                  state <= S_DONE;
                end else begin
                  idx   <= idx + 1'b1;
                  state <= S_LOAD;
                end
              end else begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          S_DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            led   <= 4'b0000;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_sequence_player.sv
// tb/tb_simon_sequence_player.sv - directed self-checking bench for simon_sequence_player
module tb_simon_sequence_player;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       start;
  logic       abort;
  logic [5:0] length;
  logic [4:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] led;
  logic       busy;
  logic       done;

  logic [1:0] ram [32];

  int n_checks = 0;
  int n_fail   = 0;

  int done_cnt    = 0;
  int busy_cnt    = 0;
  int colour_cnt  = 0;
  int colour_err  = 0;
  int addr31_cnt  = 0;
  int col_base    = 0;
  logic [3:0] prev_led = 4'b0000;

  simon_sequence_player #(
    .SEQ_MAX  (32),
    .ON_TICKS (2),
    .OFF_TICKS(1)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (tick),
    .start  (start),
    .abort  (abort),
    .length (length),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .led    (led),
    .busy   (busy),
    .done   (done)
  );

  assign rd_data = ram[rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_period();
    tick = 1'b0;
    step(3);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  // Background observers: pulse/colour counters the main thread compares as deltas
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (rd_addr == 5'd31) addr31_cnt++;
    if (led != 4'b0000 && prev_led == 4'b0000) begin
      if (led != oh(ram[5'(colour_cnt - col_base)])) colour_err++;
      colour_cnt++;
    end
    prev_led = led;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [3:0] exp_led  [9] = '{4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
                               4'b0000, 4'b1000, 4'b0000, 4'b0000};
  logic [4:0] exp_addr [9] = '{5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2};

  initial begin
    int d0, b0, c0, e0, a0;
    rst_n  = 1'b0;
    tick   = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    length = '0;
    for (int i = 0; i < 32; i++) ram[i] = 2'd0;

    // reset held with tick toggling
    for (int i = 0; i < 4; i++) begin
      tick = ~tick;
      step(1);
      check("rst_led", led, 4'b0000);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_addr", rd_addr, 5'd0);
    end
    tick  = 1'b0;
    rst_n = 1'b1;
    step(2);

    // three-colour playback, tick every 4 clocks
    ram[0] = 2'd2; ram[1] = 2'd0; ram[2] = 2'd3;
    d0 = done_cnt;
    length = 6'd3;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    check("play_busy_load", busy, 1'b1);
    check("play_led_load", led, 4'b0000);
    step(1);
    check("play_led_first", led, 4'b0100);
    for (int i = 0; i < 9; i++) begin
      tick_period();
      check($sformatf("play_led_t%0d", i + 1), led, exp_led[i]);
      check($sformatf("play_addr_t%0d", i + 1), rd_addr, exp_addr[i]);
    end
    check("play_busy_end", busy, 1'b0);
    check("play_done_early", done, 1'b0);
    step(1);
    check("play_done", done, 1'b1);
    step(1);
    check("play_done_clr", done, 1'b0);
    check("play_done_cnt", done_cnt - d0, 1);

    // zero-length start
    d0 = done_cnt;
    b0 = busy_cnt;
    length = 6'd0;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    check("zero_done_e1", done, 1'b0);
    step(1);
    check("zero_done_e2", done, 1'b1);
    step(1);
    check("zero_done_clr", done, 1'b0);
    check("zero_busy_never", busy_cnt - b0, 0);
    check("zero_led", led, 4'b0000);
    check("zero_done_cnt", done_cnt - d0, 1);

    // over-length clamps to 32 entries
    for (int i = 0; i < 32; i++) ram[i] = 2'((i * 3 + 1) % 4);
    d0 = done_cnt;
    c0 = colour_cnt;
    e0 = colour_err;
    a0 = addr31_cnt;
    col_base = colour_cnt;
    length = 6'd40;
    tick   = 1'b1;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 1000 && done_cnt == d0; i++) step(1);
    tick = 1'b0;
    step(3);
    check("clamp_colours", colour_cnt - c0, 32);
    check("clamp_colour_err", colour_err - e0, 0);
    check("clamp_addr31_seen", (addr31_cnt != a0), 1'b1);
    check("clamp_done_cnt", done_cnt - d0, 1);
    check("clamp_busy", busy, 1'b0);

    // abort during the second colour's ON phase
    ram[0] = 2'd1; ram[1] = 2'd3; ram[2] = 2'd2;
    d0 = done_cnt;
    length = 6'd3;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("abort_led0", led, 4'b0010);
    tick = 1'b1;
    step(2);
    check("abort_gap", led, 4'b0000);
    step(1);
    tick = 1'b0;
    step(1);
    check("abort_led1", led, 4'b1000);
    check("abort_addr1", rd_addr, 5'd1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_led", led, 4'b0000);
    check("abort_busy", busy, 1'b0);
    check("abort_addr", rd_addr, 5'd0);
    step(4);
    check("abort_no_done", done_cnt - d0, 0);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("replay_busy", busy, 1'b1);
    check("replay_addr", rd_addr, 5'd0);
    step(1);
    check("replay_led", led, 4'b0010);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    step(1);

    // restart while busy and tick during LOAD are both ignored
    ram[0] = 2'd0; ram[1] = 2'd1;
    d0 = done_cnt;
    length = 6'd2;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    tick  = 1'b1;
    step(1);
    check("ign_led_a", led, 4'b0001);
    tick  = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("ign_led_b", led, 4'b0001);
    check("ign_busy", busy, 1'b1);
    tick = 1'b1;
    step(1);
    check("ign_on_t1", led, 4'b0001);
    step(1);
    check("ign_on_t2", led, 4'b0000);
    step(1);
    check("ign_addr1", rd_addr, 5'd1);
    step(1);
    check("ign_led1", led, 4'b0010);
    step(1);
    check("ign_led1_t1", led, 4'b0010);
    step(1);
    check("ign_led1_t2", led, 4'b0000);
    step(1);
    check("ign_busy_end", busy, 1'b0);
    tick = 1'b0;
    step(1);
    check("ign_done", done, 1'b1);
    step(3);
    check("ign_done_cnt", done_cnt - d0, 1);
    check("ign_no_restart", busy, 1'b0);

    // async reset mid-playback
    ram[0] = 2'd3;
    d0 = done_cnt;
    length = 6'd1;
    start  = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("arst_led_pre", led, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_led", led, 4'b0000);
    check("arst_busy", busy, 1'b0);
    check("arst_addr", rd_addr, 5'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4);
    check("arst_no_done", done_cnt - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
